// File: rtl/hit_pkg.sv
// Shared types and constants for the hit collector: hit word, slot-tagged word, FSM state.
package hit_pkg;

  localparam int STUB_W = 8;
  localparam int BEND_W = 5;
  localparam int HIT_W  = STUB_W + BEND_W;
  localparam int SLOT_W = 2;
  localparam int TAG_W  = SLOT_W + HIT_W;

  typedef struct packed {
    logic [STUB_W-1:0] stub;
    logic [BEND_W-1:0] bend;
  } hit_t;

  // Output word without its timestamp; the top prepends ts[TS_W-1:0].
  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    hit_t              hit;
  } out_word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  function automatic out_word_t tag_hit(input logic [SLOT_W-1:0] slot, input hit_t h);
    out_word_t w;
    w.slot = slot;
    w.hit  = h;
    return w;
  endfunction

endpackage

// File: rtl/hit_collector_if.sv
// Valid/ready output stream of the hit collector; master drives words, slave accepts them.
interface hit_collector_if
  import hit_pkg::*;
#(
  parameter int TS_W = 9
);

  logic                  out_valid;
  logic                  out_ready;
  logic [TS_W+TAG_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/hit_fifo.sv
// Three-write / one-read compacting FIFO: writes the lowest-numbered valid slots that fit.
module hit_fifo
  import hit_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int W     = 24,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    i_vld,
  input  logic [W-1:0]  i_data [3],
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_count_nxt,
  output logic [1:0]    o_drop
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [CW-1:0] w_free;
  logic [1:0]    w_before [3];
  logic [2:0]    w_acc;
  logic [1:0]    w_nvld;
  logic [1:0]    w_nacc;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_free      = CW'(DEPTH) - r_count;
    w_before[0] = 2'd0;
    w_before[1] = {1'b0, i_vld[0]};
    w_before[2] = {1'b0, i_vld[0]} + {1'b0, i_vld[1]};
    w_acc       = 3'b000;
    // A slot fits only if every earlier valid slot fit too, so its offset is its write index.
    for (int k = 0; k < 3; k++) begin
      w_acc[k] = i_vld[k] && (CW'(w_before[k]) < w_free);
    end
    w_nvld      = w_before[2] + {1'b0, i_vld[2]};
    w_nacc      = {1'b0, w_acc[0]} + {1'b0, w_acc[1]} + {1'b0, w_acc[2]};
    o_drop      = w_nvld - w_nacc;
    o_count_nxt = r_count + CW'(w_nacc) - CW'(i_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_nacc);
      r_count  <= o_count_nxt;
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (w_acc[k]) begin
        r_mem[r_wr_ptr + AW'(w_before[k])] <= i_data[k];
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/hit_collector.sv
// Hit collector: timestamps up to three hits per BX, buffers them, streams them out in order.
// Optional macro HIT_COLLECTOR_OVF_CNT_EN adds a saturating dropped-hit counter ovf_cnt.
module hit_collector
  import hit_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hit1_dv,
  input  logic hit2_dv,
  input  logic hit3_dv,
  input  hit_t hit1_data,
  input  hit_t hit2_data,
  input  hit_t hit3_data,
  hit_collector_if.master out_if,
  output logic ovf,
  output logic proto_err
`ifdef HIT_COLLECTOR_OVF_CNT_EN
  , output logic [15:0] ovf_cnt
`endif
);

  localparam int W  = TS_W + TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [TS_W-1:0] r_ts;
  state_e          r_state;
  state_e          w_state_nxt;

  logic [2:0]    w_vld;
  logic [W-1:0]  w_data [3];
  logic [W-1:0]  w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_nxt;
  logic [1:0]    w_drop;
  logic          w_pop;
  logic          w_proto;

  assign w_vld     = en ? {hit3_dv, hit2_dv, hit1_dv} : 3'b000;
  assign w_data[0] = {r_ts, tag_hit(2'd1, hit1_data)};
  assign w_data[1] = {r_ts, tag_hit(2'd2, hit2_data)};
  assign w_data[2] = {r_ts, tag_hit(2'd3, hit3_data)};
  assign w_pop     = (r_state == ST_HOLD) && out_if.out_ready;
  assign w_proto   = en && ((hit2_dv && !hit1_dv) || (hit3_dv && !hit2_dv));

  hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_vld       (w_vld),
    .i_data      (w_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_count_nxt (w_count_nxt),
    .o_drop      (w_drop)
  );

  // EMPTY waits one edge after the first write, so a fresh hit is presented after edge N+1.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_EMPTY) begin
      if (w_count != '0) w_state_nxt = ST_HOLD;
    end else if (w_pop && (w_count_nxt == '0)) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts      <= '0;
      r_state   <= ST_EMPTY;
      ovf       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (en) r_ts <= r_ts + 1'b1;
      if (w_drop != 2'd0) ovf <= 1'b1;
      if (w_proto) proto_err <= 1'b1;
    end
  end

`ifdef HIT_COLLECTOR_OVF_CNT_EN
  logic [16:0] w_cnt_sum;
  assign w_cnt_sum = {1'b0, ovf_cnt} + 17'(w_drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt <= '0;
    else        ovf_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
  end
`endif

  assign out_if.out_valid = (r_state == ST_HOLD);
  assign out_if.out_data  = (r_state == ST_HOLD) ? w_head : '0;

endmodule

// File: tb/tb_hit_collector.sv
// Scoreboard bench for hit_collector: reference model queues expected words, a monitor pops them.
module tb_hit_collector;

  localparam int FIFO_DEPTH = 16;
  localparam int TS_W       = 9;
  localparam int W          = TS_W + 15;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic        hit1_dv = 1'b0, hit2_dv = 1'b0, hit3_dv = 1'b0;
  logic [12:0] hit1_data = '0, hit2_data = '0, hit3_data = '0;
  logic        ovf, proto_err;
`ifdef HIT_COLLECTOR_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  hit_collector_if #(.TS_W(TS_W)) bus ();

  hit_collector #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TS_W       (TS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .hit1_dv   (hit1_dv),
    .hit2_dv   (hit2_dv),
    .hit3_dv   (hit3_dv),
    .hit1_data (hit1_data),
    .hit2_data (hit2_data),
    .hit3_data (hit3_data),
    .out_if    (bus),
    .ovf       (ovf),
    .proto_err (proto_err)
`ifdef HIT_COLLECTOR_OVF_CNT_EN
    , .ovf_cnt (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: words still inside the DUT, in leaving order.
  logic [W-1:0] exp_q [$];
  int           m_occ;
  bit           pending_pop;
  int           m_ts;
  bit           m_ovf, m_proto;
  int           m_ovf_cnt;
  int           n_words;
  logic [W-1:0] last_word;

  bit [2:0]     md_dv;
  logic [12:0]  md_d [3];
  int           md_free, md_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_occ = 0; pending_pop = 0; m_ts = 0;
    m_ovf = 0; m_proto = 0; m_ovf_cnt = 0;
  endtask

  // Model: each en edge admits valid slots in order while free space remains.
  always @(posedge clk) begin
    if (rst_n) begin
      md_dv = {hit3_dv, hit2_dv, hit1_dv};
      md_d[0] = hit1_data; md_d[1] = hit2_data; md_d[2] = hit3_data;
      if (en) begin
        md_free = FIFO_DEPTH - m_occ;
        md_acc  = 0;
        for (int k = 0; k < 3; k++) begin
          if (md_dv[k]) begin
            if (md_acc < md_free) begin
              exp_q.push_back((W'(m_ts) << 15) | (W'(k + 1) << 13) | W'(md_d[k]));
              md_acc++;
            end else begin
              m_ovf = 1;
              if (m_ovf_cnt < 65535) m_ovf_cnt++;
            end
          end
        end
        if ((md_dv[1] && !md_dv[0]) || (md_dv[2] && !md_dv[1])) m_proto = 1;
        m_ts  = (m_ts + 1) % (1 << TS_W);
        m_occ = m_occ + md_acc;
      end
      if (pending_pop) begin
        m_occ--;
        pending_pop = 0;
      end
    end
  end

  // Monitor: compare flags every cycle and each presented word against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ovf", ovf, m_ovf);
      check("proto_err", proto_err, m_proto);
`ifdef HIT_COLLECTOR_OVF_CNT_EN
      check("ovf_cnt", ovf_cnt, m_ovf_cnt);
`endif
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got 0x%0h with nothing expected", bus.out_data);
        end else begin
          check("out_data", bus.out_data, exp_q[0]);
          if (bus.out_ready) begin
            last_word = exp_q.pop_front();
            pending_pop = 1;
            n_words++;
          end
        end
      end
    end
  end

  task automatic cycle_d(input bit e, input bit [2:0] dv, input bit rdy,
                         input logic [12:0] d1, input logic [12:0] d2, input logic [12:0] d3);
    en = e;
    {hit3_dv, hit2_dv, hit1_dv} = dv;
    hit1_data = d1; hit2_data = d2; hit3_data = d3;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit e, input bit [2:0] dv, input bit rdy);
    cycle_d(e, dv, rdy, 13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)),
            13'($urandom_range(0, 8191)));
  endtask

  task automatic do_reset();
    en = 0; {hit3_dv, hit2_dv, hit1_dv} = 3'b000; bus.out_ready = 0;
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    n_words = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      cycle(0, 3'b000, 1);
      n++;
    end
    cycle(0, 3'b000, 1);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    bus.out_ready = 0;
    #2;

    // Reset state and single-hit latency.
    do_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_proto_err", proto_err, 0);
    cycle_d(1, 3'b001, 1, 13'h1A5F, 13'h0, 13'h0);
    check("t1_not_yet_valid", bus.out_valid, 0);
    cycle(0, 3'b000, 1);
    check("t1_valid", bus.out_valid, 1);
    check("t1_word", bus.out_data, {9'd0, 2'd1, 13'h1A5F});
    cycle(0, 3'b000, 1);
    check("t1_valid_one_cycle", bus.out_valid, 0);
    drain();

    // Three hits in BX 5 leave as slots 1,2,3 with ts=5.
    do_reset();
    repeat (5) cycle(1, 3'b000, 1);
    cycle(1, 3'b111, 1);
    for (int s = 1; s <= 3; s++) begin
      cycle(0, 3'b000, 1);
      check("t2_valid", bus.out_valid, 1);
      check("t2_ts", bus.out_data[23:15], 5);
      check("t2_slot", bus.out_data[14:13], s);
    end
    cycle(0, 3'b000, 1);
    check("t2_empty_after", bus.out_valid, 0);
    drain();

    // Overflow: 18 hits into 16 entries with no drain.
    do_reset();
    repeat (6) cycle(1, 3'b111, 0);
    cycle(0, 3'b000, 0);
    check("t3_ovf", ovf, 1);
`ifdef HIT_COLLECTOR_OVF_CNT_EN
    check("t3_ovf_cnt", ovf_cnt, 2);
`endif
    check("t3_valid_stalled", bus.out_valid, 1);
    drain();
    check("t3_words_drained", n_words, 16);

    // Slot-order violation still captures the hit.
    do_reset();
    cycle(1, 3'b010, 1);
    cycle(0, 3'b000, 1);
    check("t4_proto_err", proto_err, 1);
    check("t4_slot", bus.out_data[14:13], 2);
    drain();

    // Timestamp wrap: the 513th hit carries ts=0.
    do_reset();
    repeat (513) cycle(1, 3'b001, 1);
    drain();
    check("t5_words", n_words, 513);
    check("t5_last_ts", last_word[23:15], 0);
    check("t5_last_slot", last_word[14:13], 1);

    // Mid-stream asynchronous reset discards five queued words.
    do_reset();
    cycle(1, 3'b111, 0);
    cycle(1, 3'b110, 0);
    cycle(0, 3'b000, 0);
    check("t6_valid_before", bus.out_valid, 1);
    check("t6_proto_before", proto_err, 1);
    #2;
    rst_n = 0;
    model_clear();
    #1;
    check("t6_valid_in_reset", bus.out_valid, 0);
    check("t6_data_in_reset", bus.out_data, 0);
    check("t6_proto_in_reset", proto_err, 0);
    check("t6_ovf_in_reset", ovf, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    n_words = 0;
    repeat (3) cycle(0, 3'b000, 1);
    check("t6_nothing_after", bus.out_valid, 0);
    cycle(1, 3'b001, 1);
    drain();
    check("t6_first_words", n_words, 1);
    check("t6_first_ts", last_word[23:15], 0);

    // Randomized traffic with back-pressure.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
